// File: rtl/inst_fetch_queue.sv
// Instruction fetch stage: owns the fetch PC, issues one SRAM read per cycle and
// buffers returned {pc, inst} pairs in a small FIFO ahead of the F/D register.
module inst_fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       redirect_valid,
  input  logic [31:0]                redirect_pc,
  input  logic                       stop,
  output logic                       im_req,
  output logic [31:0]                im_addr,
  input  logic [31:0]                im_rdata,
  output logic                       out_valid,
  output logic [31:0]                out_inst,
  output logic [31:0]                out_pc,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  typedef enum logic {RUN, STOPPED} state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } entry_t;

  state_t          state, state_nxt;
  entry_t          mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count;
  logic            inflight;
  logic [31:0]     fetch_pc, rsp_pc;
  logic [31:0]     last_pc, last_inst;
  logic [CW:0]     used;
  logic            have_credit, push, pop;
  logic            unused_lsbs;

  assign unused_lsbs = ^redirect_pc[1:0];

  // Outstanding response counts against capacity so a push can never overflow.
  assign used        = {1'b0, count} + (CW+1)'(inflight);
  assign have_credit = used < (CW+1)'(DEPTH);

  always_comb begin
    state_nxt = state;
    case (state)
      RUN:     if (stop)  state_nxt = STOPPED;
      STOPPED: if (!stop) state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  always_comb begin
    im_req    = rst && (state == RUN) && !stop && !redirect_valid && have_credit;
    push      = inflight && !redirect_valid;
    out_valid = (count != '0);
    pop       = out_valid && out_ready && !redirect_valid;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= RUN;
      fetch_pc  <= RESET_PC;
      rsp_pc    <= '0;
      inflight  <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      last_pc   <= '0;
      last_inst <= '0;
    end else if (redirect_valid) begin
      state    <= state_nxt;
      fetch_pc <= {redirect_pc[31:2], 2'b00};
      inflight <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else begin
      state    <= state_nxt;
      inflight <= im_req;
      if (im_req) begin
        fetch_pc <= fetch_pc + 32'd4;
        rsp_pc   <= fetch_pc;
      end
      if (push) begin
        mem[wr_ptr] <= '{pc: rsp_pc, inst: im_rdata};
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr    <= rd_ptr + 1'b1;
        last_pc   <= mem[rd_ptr].pc;
        last_inst <= mem[rd_ptr].inst;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // An empty queue presents the most recently consumed pair.
  assign out_pc    = out_valid ? mem[rd_ptr].pc   : last_pc;
  assign out_inst  = out_valid ? mem[rd_ptr].inst : last_inst;
  assign im_addr   = fetch_pc;
  assign occupancy = count;

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Bench for inst_fetch_queue: SRAM model returns word index, scoreboard holds
// the PCs expected at the consumer in order.
module tb_inst_fetch_queue;
  logic        clk = 1'b0, rst = 1'b0;
  logic        redirect_valid = 1'b0, stop = 1'b0, out_ready = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        im_req, out_valid;
  logic [31:0] im_addr, out_inst, out_pc;
  logic [31:0] im_rdata = '0;
  logic [2:0]  occupancy;

  int          n_chk = 0, n_fail = 0, n_pop = 0;
  logic [31:0] sb[$];

  inst_fetch_queue #(.DEPTH(4), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .stop(stop), .im_req(im_req), .im_addr(im_addr), .im_rdata(im_rdata),
    .out_valid(out_valid), .out_inst(out_inst), .out_pc(out_pc),
    .out_ready(out_ready), .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  // Synchronous SRAM with SRAM[i] = i
  always @(posedge clk) if (im_req) im_rdata <= im_addr >> 2;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic sb_check();
    logic [31:0] e;
    if (rst && !redirect_valid && out_valid && out_ready) begin
      n_pop++;
      if (sb.size() == 0) chk("sb_empty", 32'(sb.size()), 32'd1);
      else begin
        e = sb.pop_front();
        chk("sb_pc", out_pc, e);
        chk("sb_inst", out_inst, e >> 2);
      end
    end
  endtask

  task automatic step();
    #1;
    sb_check();
    @(negedge clk);
  endtask

  task automatic push_seq(input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) sb.push_back(base + 32'(4*i));
  endtask

  task automatic do_reset();
    rst = 1'b0; redirect_valid = 1'b0; stop = 1'b0; out_ready = 1'b0;
    sb.delete();
    repeat (2) @(negedge clk);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_occ", 32'(occupancy), 32'd0);
    chk("rst_addr", im_addr, 32'h0);
    chk("rst_pc", out_pc, 32'h0);
    chk("rst_inst", out_inst, 32'h0);
    #1 chk("rst_req", 32'(im_req), 32'd0);
    rst = 1'b1;
    push_seq(32'h0, 32);
  endtask

  initial begin
    // 1: streaming from reset, latency and order
    do_reset();
    out_ready = 1'b1;
    #1;
    chk("t1_req0", 32'(im_req), 32'd1);
    chk("t1_addr0", im_addr, 32'h0);
    step();
    chk("t1_lat_v", 32'(out_valid), 32'd0);
    chk("t1_addr1", im_addr, 32'h4);
    step();
    chk("t1_v", 32'(out_valid), 32'd1);
    chk("t1_pc0", out_pc, 32'h0);
    chk("t1_inst0", out_inst, 32'h0);
    chk("t1_addr2", im_addr, 32'h8);
    step();
    chk("t1_pc1", out_pc, 32'h4);
    chk("t1_inst1", out_inst, 32'h1);
    step();
    chk("t1_pc2", out_pc, 32'h8);
    chk("t1_inst2", out_inst, 32'h2);
    chk("t1_addr4", im_addr, 32'h10);
    repeat (6) step();

    // 2: saturate with out_ready low, then drain without gaps
    do_reset();
    repeat (6) step();
    chk("t2_occ", 32'(occupancy), 32'd4);
    #1 chk("t2_req", 32'(im_req), 32'd0);
    repeat (3) step();
    chk("t2_occ_hold", 32'(occupancy), 32'd4);
    chk("t2_head_hold", out_pc, 32'h0);
    chk("t2_pc_hold", im_addr, 32'h10);
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      chk("t2_drain_v", 32'(out_valid), 32'd1);
      chk("t2_drain_pc", out_pc, 32'(4*k));
      step();
    end

    // 3: redirect with FIFO half full and a response in flight
    do_reset();
    repeat (3) step();
    chk("t3_occ", 32'(occupancy), 32'd2);
    out_ready = 1'b1;
    redirect_valid = 1'b1; redirect_pc = 32'h103;
    sb.delete(); push_seq(32'h100, 16);
    #1 chk("t3_req_redir", 32'(im_req), 32'd0);
    step();
    redirect_valid = 1'b0;
    chk("t3_v", 32'(out_valid), 32'd0);
    chk("t3_occ0", 32'(occupancy), 32'd0);
    chk("t3_addr", im_addr, 32'h100);
    #1 chk("t3_req", 32'(im_req), 32'd1);
    step(); step();
    chk("t3_pc", out_pc, 32'h100);
    chk("t3_inst", out_inst, 32'h40);
    repeat (4) step();

    // 4: redirect as a response returns, then back-to-back redirects
    redirect_valid = 1'b1; redirect_pc = 32'h200;
    sb.delete(); push_seq(32'h200, 16);
    step();
    redirect_valid = 1'b0;
    step(); step();
    chk("t4_pc", out_pc, 32'h200);
    repeat (3) step();
    redirect_valid = 1'b1; redirect_pc = 32'h500;
    step();
    redirect_pc = 32'h600;
    sb.delete(); push_seq(32'h600, 16);
    #1 chk("t4_req_b2b", 32'(im_req), 32'd0);
    step();
    redirect_valid = 1'b0;
    chk("t4_addr", im_addr, 32'h600);
    step(); step();
    chk("t4_pc2", out_pc, 32'h600);
    repeat (3) step();

    // 5: stop with 2 queued and 1 in flight
    do_reset();
    repeat (3) step();
    stop = 1'b1;
    #1 chk("t5_req_stop", 32'(im_req), 32'd0);
    step();
    chk("t5_occ3", 32'(occupancy), 32'd3);
    out_ready = 1'b1;
    n_pop = 0;
    for (int k = 0; k < 5; k++) begin
      #1 chk("t5_req_off", 32'(im_req), 32'd0);
      step();
    end
    chk("t5_drained", 32'(n_pop), 32'd3);
    chk("t5_empty", 32'(out_valid), 32'd0);
    chk("t5_addr", im_addr, 32'hC);
    stop = 1'b0;
    step();
    #1;
    chk("t5_resume_req", 32'(im_req), 32'd1);
    chk("t5_resume_addr", im_addr, 32'hC);
    repeat (6) step();

    // 6: PC wrap, then reset mid-stream
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFF8;
    sb.delete(); push_seq(32'hFFFF_FFF8, 16);
    step();
    redirect_valid = 1'b0;
    chk("t6_addr", im_addr, 32'hFFFF_FFF8);
    step(); step();
    chk("t6_pc0", out_pc, 32'hFFFF_FFF8);
    step();
    chk("t6_pc1", out_pc, 32'hFFFF_FFFC);
    step();
    chk("t6_pc2", out_pc, 32'h0);
    chk("t6_inst2", out_inst, 32'h0);
    rst = 1'b0;
    sb.delete();
    step();
    chk("t6_rst_v", 32'(out_valid), 32'd0);
    chk("t6_rst_occ", 32'(occupancy), 32'd0);
    chk("t6_rst_addr", im_addr, 32'h0);
    chk("t6_rst_pc", out_pc, 32'h0);
    chk("t6_rst_inst", out_inst, 32'h0);
    #1 chk("t6_rst_req", 32'(im_req), 32'd0);
    rst = 1'b1;
    push_seq(32'h0, 16);
    step(); step();
    chk("t6_restart_v", 32'(out_valid), 32'd1);
    chk("t6_restart_pc", out_pc, 32'h0);
    repeat (4) step();

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
